imm_pack: RTL

// - Inverse of the immediate sign-extender: packs a 32-bit immediate into the scattered inst[31:7] bit positions for a given

---
 rtl/imm_pack.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imm_pack.sv
// Packs a 32-bit immediate into its scattered inst[31:7] positions for a given format and
// merges it over a base instruction word; 2-stage valid/ready pipeline with range-error flagging.
module imm_pack #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_imm,
    input  logic [24:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_din,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    // Immediate format codes; 3'd6 and 3'd7 are unassigned and always flagged.
    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_SHIFT = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_B     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;

    logic        s1_v;
    logic [2:0]  s1_op;
    logic [31:0] s1_imm;
    logic [24:0] s1_base;
    logic        s2_adv;
    logic [24:0] pk_din;
    logic        pk_err;
    logic        hi11_ok;
    logic        hi12_ok;
    logic        hi20_ok;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_v || s2_adv;

    // Sign-extension range checks: upper bits must all match the sign bit.
    assign hi11_ok = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign hi12_ok = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign hi20_ok = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

    // Scatter immediate bits over the base word; bits outside the format pass through.
    always_comb begin
        pk_din = s1_base;
        pk_err = 1'b0;
        case (s1_op)
            IMM_I: begin
                pk_din[24:13] = s1_imm[11:0];
                pk_err        = !hi11_ok;
            end
            IMM_SHIFT: begin
                pk_din[17:13] = s1_imm[4:0];
                pk_err        = |s1_imm[31:5];
            end
            IMM_S: begin
                pk_din[24:18] = s1_imm[11:5];
                pk_din[4:0]   = s1_imm[4:0];
                pk_err        = !hi11_ok;
            end
            IMM_U: begin
                pk_din[24:5] = s1_imm[31:12];
                pk_err       = |s1_imm[11:0];
            end
            IMM_B: begin
                pk_din[24]    = s1_imm[12];
                pk_din[0]     = s1_imm[11];
                pk_din[23:18] = s1_imm[10:5];
                pk_din[4:1]   = s1_imm[4:1];
                pk_err        = s1_imm[0] || !hi12_ok;
            end
            IMM_J: begin
                pk_din[24]    = s1_imm[20];
                pk_din[12:5]  = s1_imm[19:12];
                pk_din[13]    = s1_imm[11];
                pk_din[23:14] = s1_imm[10:1];
                pk_err        = s1_imm[0] || !hi20_ok;
            end
            default: pk_err = 1'b1;
        endcase
    end

    // Stage 1: capture request beat.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            s1_v    <= 1'b0;
            s1_op   <= 3'd0;
            s1_imm  <= 32'd0;
            s1_base <= 25'd0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_imm  <= in_imm;
                s1_base <= in_base;
            end
        end
    end

    // Stage 2: packed result, held while the consumer stalls.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            out_valid <= 1'b0;
            out_din   <= 25'd0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_din <= pk_din;
                out_err <= pk_err;
            end
        end
    end

    // Saturating count of errored beats delivered.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
